sram_req_adapter: RTL and testbench

- Upstream stage of the 64K x 32 SRAM wrapper.
- Converts a valid/ready request channel (byte address, byte enables, write flag) into the wrapper's active-low chip-select / active-low write-enable interface.
- Returns read data and write acknowledges on a valid/ready response channel.
- One transaction outstanding; range and alignment checks are done here, and a rejected request never reaches the SRAM.

---
 rtl/sram_req_adapter.sv | 135 +++++++++++++
 tb/tb_sram_req_adapter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready request front end for the 64K x 32 SRAM wrapper.
// It decodes and checks the byte address and drives the active-low SRAM
// strobes in the accept cycle only. Read data and write or error
// acknowledges come back on a valid/ready response channel. Only one
// transaction is outstanding at a time.
//
// Handshake: a transfer happens on a rising clk_i edge when valid and ready
// are both high in the cycle before it. Once valid is raised, the payload is
// held stable until that transfer. Ready may depend combinationally on the
// downstream ready, but valid never depends on ready.
module sram_req_adapter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          SRAM_AW    = 16,
    parameter int          RD_LATENCY = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [31:0]        req_addr_i,
    input  logic               req_we_i,
    input  logic [31:0]        req_wdata_i,
    input  logic [3:0]         req_be_i,

    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [31:0]        rsp_rdata_o,
    output logic               rsp_err_o,

    output logic               sram_csb_o,
    output logic               sram_we_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_wdata_o,
    output logic [3:0]         sram_wmask_o,
    input  logic [31:0]        sram_rdata_i,

    output logic [1:0]         state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    // The window is sized in 33 bits so that 4 << SRAM_AW cannot overflow.
    localparam logic [32:0] WINDOW    = 33'd4 << SRAM_AW;
    localparam logic [1:0]  WAIT_INIT = 2'(RD_LATENCY - 1);

    state_t      state;
    logic [1:0]  wait_cnt;
    logic [31:0] off;
    logic        addr_ok;
    logic        accept;
    logic        sel;

    // Address decode. The offset is a modular difference, so addresses below
    // the base are rejected by the explicit >= test and never wrap into the window.
    assign off     = req_addr_i - BASE_ADDR;
    assign addr_ok = (req_addr_i >= BASE_ADDR) &&
                     ({1'b0, off} < WINDOW) &&
                     (req_addr_i[1:0] == 2'b00);

    // Ready is high when idle, or when the pending response leaves this cycle.
    // It is held low while reset is asserted.
    assign req_ready_o = !rst_i &&
                         ((state == IDLE) || ((state == RESP) && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;
    assign sel         = accept && addr_ok;

    // The SRAM is driven only in the accept cycle of an in-range request.
    // Otherwise all SRAM outputs are parked at known idle values.
    assign sram_csb_o   = !sel;
    assign sram_we_o    = sel ? !req_we_i : 1'b1;
    assign sram_addr_o  = sel ? off[SRAM_AW+1:2] : '0;
    assign sram_wdata_o = sel ? req_wdata_i : 32'h0;
    assign sram_wmask_o = sel ? (req_we_i ? req_be_i : 4'hF) : 4'h0;

    assign state_dbg_o = state;

    // Transaction FSM. It owns the response registers and the read wait counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= 2'd0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else if (accept) begin
            if (!addr_ok) begin
                state       <= RESP;
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= 32'h0;
                rsp_err_o   <= 1'b1;
            end else if (req_we_i) begin
                state       <= RESP;
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= 32'h0;
                rsp_err_o   <= 1'b0;
            end else begin
                state       <= RD_WAIT;
                wait_cnt    <= WAIT_INIT;
                rsp_valid_o <= 1'b0;
                rsp_rdata_o <= 32'h0;
                rsp_err_o   <= 1'b0;
            end
        end else begin
            case (state)
                RD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= sram_rdata_i;
                        rsp_err_o   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= 32'h0;
                        rsp_err_o   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_adapter.sv
// Bench for sram_req_adapter with default parameters (base 0, 64K words,
// read latency 1). A one-cycle SRAM model is attached to the SRAM port.
// Responses are checked against an expected queue filled at accept time.
module tb_sram_req_adapter;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        sram_csb_o;
    logic        sram_we_o;
    logic [15:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_wmask_o;
    logic [31:0] sram_rdata_i;
    logic [1:0]  state_dbg_o;

    sram_req_adapter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_we_i     (req_we_i),
        .req_wdata_i  (req_wdata_i),
        .req_be_i     (req_be_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .sram_csb_o   (sram_csb_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_wmask_o (sram_wmask_o),
        .sram_rdata_i (sram_rdata_i),
        .state_dbg_o  (state_dbg_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- SRAM model (1-cycle read) ----------------
    logic [31:0] mem [0:65535];
    always @(posedge clk_i) begin
        if (!sram_csb_o) begin
            if (!sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= mem[sram_addr_o];
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];              // {err, rdata}
    logic [31:0] ref_mem [int];
    int n_cmp = 0;
    int n_mis = 0;
    int rsp_count = 0;

    function automatic void push_exp(input logic [31:0] a, input logic we,
                                     input logic [31:0] d, input logic [3:0] be);
        logic ok;
        logic [31:0] w;
        ok = (a < 32'h0004_0000) && (a[1:0] == 2'b00);
        if (!ok) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (we) begin
            w = ref_mem.exists(int'(a >> 2)) ? ref_mem[int'(a >> 2)] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (be[b]) w[8*b +: 8] = d[8*b +: 8];
            ref_mem[int'(a >> 2)] = w;
            exp_q.push_back({1'b0, 32'h0});
        end else begin
            exp_q.push_back({1'b0, ref_mem[int'(a >> 2)]});
        end
    endfunction

    // Response monitor: every completed response handshake pops one expectation.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && rsp_valid_o && rsp_ready_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL rsp_unexpected: got err=%0b rdata=%h, expected no response",
                             rsp_err_o, rsp_rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    rsp_count++;
                    if ({rsp_err_o, rsp_rdata_o} !== e) begin
                        n_mis++;
                        $display("FAIL rsp_data: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                                 rsp_err_o, rsp_rdata_o, e[32], e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int          acc_tries;
    logic        acc_csb;
    logic        acc_we;
    logic [15:0] acc_addr;
    logic [3:0]  acc_wmask;
    logic [31:0] acc_wdata;

    // Entered and left at posedge+1; returns right after the accept edge.
    task automatic send(input logic [31:0] a, input logic we,
                        input logic [31:0] d, input logic [3:0] be);
        bit accepted;
        accepted    = 1'b0;
        req_addr_i  = a;
        req_we_i    = we;
        req_wdata_i = d;
        req_be_i    = be;
        req_valid_i = 1'b1;
        acc_tries   = 0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk_i);
            acc_tries++;
            if (req_ready_o) begin
                accepted  = 1'b1;
                acc_csb   = sram_csb_o;
                acc_we    = sram_we_o;
                acc_addr  = sram_addr_o;
                acc_wmask = sram_wmask_o;
                acc_wdata = sram_wdata_o;
                push_exp(a, we, d, be);
            end
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        if (!accepted) begin
            n_cmp++; n_mis++;
            $display("FAIL send_timeout: addr=%h not accepted in 50 cycles", a);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk_i); #1;
        end
        @(posedge clk_i); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        req_addr_i = 32'h0; req_we_i = 1'b0; req_wdata_i = 32'h0; req_be_i = 4'h0;
        #3 req_valid_i = 1'b1; req_we_i = 1'b1;
        #1;
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
        n_cmp++; if (req_ready_o !== 1'b0) begin n_mis++; $display("FAIL reset_req_ready: got %b expected 0", req_ready_o); end
        n_cmp++; if (sram_csb_o !== 1'b1) begin n_mis++; $display("FAIL reset_csb: got %b expected 1", sram_csb_o); end
        n_cmp++; if ({sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o} !== {1'b1, 16'h0, 32'h0, 4'h0}) begin
            n_mis++; $display("FAIL reset_sram_bus: got we=%b addr=%h wdata=%h mask=%h expected 1/0/0/0",
                              sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o); end
        n_cmp++; if ({rsp_rdata_o, rsp_err_o, state_dbg_o} !== {32'h0, 1'b0, 2'd0}) begin
            n_mis++; $display("FAIL reset_rsp_regs: got rdata=%h err=%b state=%0d expected 0/0/0",
                              rsp_rdata_o, rsp_err_o, state_dbg_o); end
        req_valid_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;
        send(32'h0000_0000, 1'b1, 32'h1234_5678, 4'hF);
        n_cmp++; if (acc_tries !== 1) begin n_mis++; $display("FAIL reset_first_accept: got %0d tries expected 1", acc_tries); end
        wait_drain();
    endtask

    task automatic test_write_read();
        send(32'h10, 1'b1, 32'hCAFE_BABE, 4'hF);
        n_cmp++; if ({acc_csb, acc_we, acc_addr} !== {1'b0, 1'b0, 16'h0004}) begin
            n_mis++; $display("FAIL wr_sram_drive: got csb=%b we=%b addr=%h expected 0/0/0004", acc_csb, acc_we, acc_addr); end
        n_cmp++; if ({acc_wmask, acc_wdata} !== {4'hF, 32'hCAFE_BABE}) begin
            n_mis++; $display("FAIL wr_sram_data: got mask=%h wdata=%h expected F/cafebabe", acc_wmask, acc_wdata); end
        @(negedge clk_i);
        n_cmp++; if ({rsp_valid_o, rsp_err_o} !== 2'b10) begin
            n_mis++; $display("FAIL wr_rsp_latency: got valid=%b err=%b expected 1/0", rsp_valid_o, rsp_err_o); end
        @(posedge clk_i); #1;
        send(32'h10, 1'b0, 32'h0, 4'h0);
        n_cmp++; if ({acc_csb, acc_we, acc_wmask} !== {1'b0, 1'b1, 4'hF}) begin
            n_mis++; $display("FAIL rd_sram_drive: got csb=%b we=%b mask=%h expected 0/1/F", acc_csb, acc_we, acc_wmask); end
        @(negedge clk_i);
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL rd_early_valid: got %b expected 0", rsp_valid_o); end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        n_cmp++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'hCAFE_BABE}) begin
            n_mis++; $display("FAIL rd_latency_data: got valid=%b rdata=%h expected 1/cafebabe", rsp_valid_o, rsp_rdata_o); end
        @(posedge clk_i); #1;
        wait_drain();
    endtask

    task automatic test_partial_write();
        send(32'h10, 1'b1, 32'h1122_3344, 4'b0101);
        n_cmp++; if (acc_wmask !== 4'b0101) begin n_mis++; $display("FAIL partial_mask: got %b expected 0101", acc_wmask); end
        send(32'h10, 1'b0, 32'h0, 4'h0);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        n_cmp++; if (rsp_rdata_o !== 32'hCA22_BA44) begin n_mis++; $display("FAIL partial_readback: got %h expected ca22ba44", rsp_rdata_o); end
        @(posedge clk_i); #1;
        // be=0 write still reaches the SRAM with an empty mask and changes nothing
        send(32'h20, 1'b1, 32'hDEAD_BEEF, 4'hF);
        send(32'h20, 1'b1, 32'h0000_0000, 4'h0);
        n_cmp++; if ({acc_csb, acc_wmask} !== {1'b0, 4'h0}) begin
            n_mis++; $display("FAIL be0_drive: got csb=%b mask=%h expected 0/0", acc_csb, acc_wmask); end
        send(32'h20, 1'b0, 32'h0, 4'h0);
        // last word of the window is in range
        send(32'h0003_FFFC, 1'b1, 32'h5566_7788, 4'hF);
        n_cmp++; if ({acc_csb, acc_addr} !== {1'b0, 16'hFFFF}) begin
            n_mis++; $display("FAIL top_word: got csb=%b addr=%h expected 0/ffff", acc_csb, acc_addr); end
        send(32'h0003_FFFC, 1'b0, 32'h0, 4'h0);
        wait_drain();
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic        wes   [4];
        addrs[0] = 32'h0004_0000; wes[0] = 1'b0;
        addrs[1] = 32'h0000_0013; wes[1] = 1'b1;
        addrs[2] = 32'hFFFF_FFFC; wes[2] = 1'b1;
        addrs[3] = 32'h0000_0102; wes[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(addrs[i], wes[i], 32'hFFFF_FFFF, 4'hF);
            n_cmp++; if (acc_csb !== 1'b1) begin n_mis++; $display("FAIL err_csb[%0d]: got %b expected 1", i, acc_csb); end
            @(negedge clk_i);
            n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
                n_mis++; $display("FAIL err_rsp[%0d]: got valid=%b err=%b rdata=%h expected 1/1/0",
                                  i, rsp_valid_o, rsp_err_o, rsp_rdata_o); end
            @(posedge clk_i); #1;
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        rsp_ready_i = 1'b0;
        send(32'h10, 1'b0, 32'h0, 4'h0);
        req_addr_i = 32'h30; req_we_i = 1'b1; req_wdata_i = 32'hA5A5_5A5A; req_be_i = 4'hF;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (req_ready_o !== 1'b0) begin n_mis++; $display("FAIL bp_rdwait_ready: got %b expected 0", req_ready_o); end
        @(posedge clk_i); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {1'b1, 1'b0, 32'hCA22_BA44}) begin
                n_mis++; $display("FAIL bp_hold[%0d]: got valid=%b err=%b rdata=%h expected 1/0/ca22ba44",
                                  i, rsp_valid_o, rsp_err_o, rsp_rdata_o); end
            n_cmp++; if ({req_ready_o, sram_csb_o} !== 2'b01) begin
                n_mis++; $display("FAIL bp_stall[%0d]: got ready=%b csb=%b expected 0/1", i, req_ready_o, sram_csb_o); end
            @(posedge clk_i); #1;
            req_valid_i = (i != 2);
        end
        req_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if ({req_ready_o, sram_csb_o, sram_we_o, sram_addr_o} !== {1'b1, 1'b0, 1'b0, 16'h000C}) begin
            n_mis++; $display("FAIL bp_b2b_accept: got ready=%b csb=%b we=%b addr=%h expected 1/0/0/000c",
                              req_ready_o, sram_csb_o, sram_we_o, sram_addr_o); end
        push_exp(32'h30, 1'b1, 32'hA5A5_5A5A, 4'hF);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if ({rsp_valid_o, rsp_err_o} !== 2'b10) begin
            n_mis++; $display("FAIL bp_b2b_rsp: got valid=%b err=%b expected 1/0", rsp_valid_o, rsp_err_o); end
        @(posedge clk_i); #1;
        send(32'h30, 1'b0, 32'h0, 4'h0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int start_cnt;
        logic [31:0] d;
        logic [3:0]  be;
        start_cnt = rsp_count;
        for (int i = 0; i < 8; i++) begin
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            req_addr_i = 32'h100 + 32'(4 * i); req_we_i = 1'b1; req_wdata_i = d; req_be_i = be;
            req_valid_i = 1'b1;
            @(negedge clk_i);
            n_cmp++; if ({req_ready_o, sram_csb_o, rsp_valid_o} !== {1'b1, 1'b0, (i != 0)}) begin
                n_mis++; $display("FAIL stream[%0d]: got ready=%b csb=%b rsp_valid=%b expected 1/0/%0b",
                                  i, req_ready_o, sram_csb_o, rsp_valid_o, (i != 0)); end
            push_exp(32'h100 + 32'(4 * i), 1'b1, d, be);
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (rsp_valid_o !== 1'b1) begin n_mis++; $display("FAIL stream_last_rsp: got %b expected 1", rsp_valid_o); end
        @(posedge clk_i); #1;
        n_cmp++; if (rsp_count - start_cnt !== 8) begin
            n_mis++; $display("FAIL stream_count: got %0d responses expected 8", rsp_count - start_cnt); end
        for (int i = 0; i < 8; i++) send(32'h100 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
        wait_drain();
    endtask

    task automatic test_random();
        int r;
        logic [31:0] a;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            if (r < 4)       send(a, 1'b1, $urandom, 4'($urandom_range(0, 15)));
            else if (r < 8)  send(a, 1'b0, 32'h0, 4'h0);
            else if (r == 8) send(32'h0004_0000 + 32'(4 * $urandom_range(0, 1000)), 1'($urandom_range(0, 1)), $urandom, 4'hF);
            else             send(a + 32'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), $urandom, 4'hF);
        end
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        // Reset during RD_WAIT: the read must vanish.
        send(32'h100, 1'b0, 32'h0, 4'h0);
        #2 rst_i = 1'b1;
        #1;
        exp_q.delete();
        n_cmp++; if ({rsp_valid_o, sram_csb_o, req_ready_o, state_dbg_o} !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            n_mis++; $display("FAIL midread_reset: got valid=%b csb=%b ready=%b state=%0d expected 0/1/0/0",
                              rsp_valid_o, sram_csb_o, req_ready_o, state_dbg_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        // Reset while a response is held: the response must vanish.
        rsp_ready_i = 1'b0;
        send(32'h104, 1'b1, 32'h0BAD_F00D, 4'hF);
        #2 rst_i = 1'b1;
        #1;
        exp_q.delete();
        n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {1'b0, 1'b0, 32'h0}) begin
            n_mis++; $display("FAIL midrsp_reset: got valid=%b err=%b rdata=%h expected 0/0/0",
                              rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL dropped_rsp[%0d]: got valid=%b expected 0", i, rsp_valid_o); end
            @(posedge clk_i); #1;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
